main_memory: RTL and testbench

Byte-addressed, big-endian unified instruction/data memory for the MIPS processor, mapped at 0x80020000. It serves single-word and fixed-length burst reads and writes over a synchronous request interface, and reports `busy` while a burst is in progress. It sits between the fetch/memory stages and the program loader, which fills it word by word before execution.

---
 rtl/main_memory.sv | 146 ++++++++++++++
 tb/tb_main_memory.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// Module   : main_memory
// Purpose  : Big-endian unified I/D memory with single-word and fixed-length
//            burst access. Optional macro MEMORY_BOUNDS_CHECK_EN drops
//            out-of-range beats instead of wrapping the offset.
// Revision : 1.0 - initial release
// ============================================================================
module main_memory #(
   parameter int                        DATA_WIDTH    = 32,
   parameter int                        ADDRESS_WIDTH = 32,
   parameter int                        DEPTH         = 1048576,
   parameter logic [ADDRESS_WIDTH-1:0]  START_ADDR    = 32'h80020000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic [1:0]               access_size,
   input  logic                     rw,
   input  logic                     enable,
   output logic                     busy,
   output logic [DATA_WIDTH-1:0]    data_out
);

   localparam int                       c_words    = DEPTH / 4;
   localparam int                       c_idx_w    = $clog2(DEPTH) - 2;
   localparam logic [ADDRESS_WIDTH-1:0] c_last_off = ADDRESS_WIDTH'(DEPTH - 4);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t                   r_state, w_state_nxt;
   logic [ADDRESS_WIDTH-3:0] r_base, w_base_nxt;
   logic [3:0]               r_beat, w_beat_nxt;
   logic [3:0]               r_last, w_last_nxt;
   logic                     r_rw, w_rw_nxt;
   logic [3:0]               w_req_last;

   logic [ADDRESS_WIDTH-3:0] w_word_addr;
   logic                     w_beat_rw;
   logic                     w_beat_en;
   logic                     w_access;
   logic [ADDRESS_WIDTH-1:0] w_offset;
   logic [c_idx_w-1:0]       w_index;
   logic                     w_in_range;
   logic                     w_unused;

   logic [DATA_WIDTH-1:0]    r_mem [0:c_words-1];
   logic [DATA_WIDTH-1:0]    r_data_out;

   always_comb begin
      w_req_last = 4'd0;
      case (access_size)
         2'b00:   w_req_last = 4'd0;
         2'b01:   w_req_last = 4'd3;
         2'b10:   w_req_last = 4'd7;
         default: w_req_last = 4'd15;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_base  <= '0;
         r_beat  <= 4'd0;
         r_last  <= 4'd0;
         r_rw    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_base  <= w_base_nxt;
         r_beat  <= w_beat_nxt;
         r_last  <= w_last_nxt;
         r_rw    <= w_rw_nxt;
      end
   end

   // In IDLE beat 0 is served straight from the request inputs.
   always_comb begin
      w_state_nxt = r_state;
      w_base_nxt  = r_base;
      w_beat_nxt  = r_beat;
      w_last_nxt  = r_last;
      w_rw_nxt    = r_rw;
      w_word_addr = r_base + (ADDRESS_WIDTH-2)'(r_beat);
      w_beat_rw   = r_rw;
      w_beat_en   = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_word_addr = address[ADDRESS_WIDTH-1:2];
            w_beat_rw   = rw;
            w_beat_en   = enable;
            if (enable) begin
               w_base_nxt = address[ADDRESS_WIDTH-1:2];
               w_rw_nxt   = rw;
               w_last_nxt = w_req_last;
               w_beat_nxt = 4'd1;
               if (w_req_last != 4'd0) begin
                  w_state_nxt = ST_BURST;
               end
            end
         end
         default: begin
            if (r_beat == r_last) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_beat_nxt = r_beat + 4'd1;
            end
         end
      endcase
   end

   assign w_access = w_beat_en & ~reset;
   assign w_offset = {w_word_addr, 2'b00} - START_ADDR;
   assign w_index  = w_offset[c_idx_w+1:2];

`ifdef MEMORY_BOUNDS_CHECK_EN
   assign w_in_range = (w_offset <= c_last_off);
`else
   // Offset wraps modulo the storage size, so every beat is serviced.
   assign w_in_range = 1'b1;
`endif

   assign w_unused = ^{address[1:0], w_offset, c_last_off};

   always_ff @(posedge clock) begin
      if (w_access && !w_beat_rw && w_in_range) begin
         r_mem[w_index] <= data_in;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_data_out <= '0;
      end else if (w_access && w_beat_rw) begin
         r_data_out <= w_in_range ? r_mem[w_index] : '0;
      end
   end

   assign data_out = r_data_out;
   assign busy     = (r_state == ST_BURST);

endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_memory
// Purpose  : Directed self-checking bench for main_memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_memory;

   localparam logic [31:0] c_base = 32'h80020000;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [1:0]  access_size;
   logic        rw;
   logic        enable;
   logic        busy;
   logic [31:0] data_out;

   int n_checks = 0;
   int n_errors = 0;
   int busy_cnt;

   main_memory u_dut (
      .clock       (clock),
      .reset       (reset),
      .address     (address),
      .data_in     (data_in),
      .access_size (access_size),
      .rw          (rw),
      .enable      (enable),
      .busy        (busy),
      .data_out    (data_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic r, input logic [1:0] sz, input logic [31:0] d);
      address     = a;
      rw          = r;
      access_size = sz;
      data_in     = d;
      enable      = 1'b1;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; rw = 1'b1; address = '0; data_in = '0; access_size = 2'b00;
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dout", data_out, 32'd0);
      step(); step();
      reset = 1'b0;

      // Single write then read
      req(c_base, 1'b0, 2'b00, 32'h27BDFFE8);
      step();
      check("single_wr_busy", 32'(busy), 32'd0);
      req(c_base, 1'b1, 2'b00, 32'h0);
      step();
      check("single_rd_dout", data_out, 32'h27BDFFE8);
      check("single_rd_busy", 32'(busy), 32'd0);
      req(c_base + 32'h4, 1'b0, 2'b00, 32'h11111111);
      step();
      check("hold_on_write", data_out, 32'h27BDFFE8);
      enable = 1'b0;

      // 16-word burst write
      req(c_base, 1'b0, 2'b11, 32'h1000);
      step();
      enable = 1'b0;
      check("bw_busy_after_edge0", 32'(busy), 32'd1);
      busy_cnt = 0;
      for (int i = 1; i < 16; i++) begin
         if (busy) busy_cnt++;
         data_in = 32'h1000 + 32'(i);
         step();
      end
      check("bw_busy_cycles", 32'(busy_cnt), 32'd15);
      check("bw_busy_end", 32'(busy), 32'd0);

      // 16-word burst read
      req(c_base, 1'b1, 2'b11, 32'h0);
      for (int i = 0; i < 16; i++) begin
         step();
         enable = 1'b0;
         check($sformatf("br_beat%0d", i), data_out, 32'h1000 + 32'(i));
      end
      check("br_busy_end", 32'(busy), 32'd0);

      // Inputs ignored during a write burst
      req(c_base + 32'h40, 1'b0, 2'b01, 32'hA0);
      step();
      for (int i = 1; i < 4; i++) begin
         address     = 32'h80020100 + 32'(i * 4);
         rw          = (i % 2 == 1);
         enable      = (i % 2 == 0);
         access_size = 2'b11;
         data_in     = 32'hA0 + 32'(i);
         step();
      end
      check("ign_wr_busy_end", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
         req(c_base + 32'h40 + 32'(i * 4), 1'b1, 2'b00, 32'h0);
         step();
         check($sformatf("ign_wr_rb%0d", i), data_out, 32'hA0 + 32'(i));
      end

      // Inputs ignored during a read burst
      req(c_base, 1'b1, 2'b01, 32'h0);
      step();
      check("ign_rd_beat0", data_out, 32'h1000);
      for (int i = 1; i < 4; i++) begin
         rw      = 1'b0;
         enable  = 1'b1;
         data_in = 32'hFFFFFFFF;
         address = c_base + 32'h200;
         step();
         check($sformatf("ign_rd_beat%0d", i), data_out, 32'h1000 + 32'(i));
      end
      enable = 1'b0;
      req(c_base + 32'h4, 1'b1, 2'b00, 32'h0);
      step();
      check("ign_rd_not_written", data_out, 32'h1001);

      // Mid-burst reset
      req(c_base + 32'h80, 1'b0, 2'b10, 32'h5000);
      step();
      enable = 1'b0;
      for (int i = 1; i < 8; i++) begin
         data_in = 32'h5000 + 32'(i);
         step();
      end
      req(c_base + 32'h80, 1'b0, 2'b10, 32'h6000);
      step();
      enable = 1'b0;
      for (int i = 1; i < 4; i++) begin
         data_in = 32'h6000 + 32'(i);
         step();
      end
      data_in = 32'h6004;
      reset = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_dout", data_out, 32'd0);
      step();
      reset = 1'b0;
      req(c_base + 32'h80, 1'b1, 2'b10, 32'h0);
      step();
      enable = 1'b0;
      check("midrst_accept_busy", 32'(busy), 32'd1);
      check("midrst_rb0", data_out, 32'h6000);
      for (int i = 1; i < 8; i++) begin
         step();
         check($sformatf("midrst_rb%0d", i), data_out,
               (i < 4) ? (32'h6000 + 32'(i)) : (32'h5000 + 32'(i)));
      end

      // Address just below the mapped window
      req(32'h8001FFFC, 1'b0, 2'b00, 32'hDEADBEEF);
      step();
      req(32'h8001FFFC, 1'b1, 2'b00, 32'h0);
      step();
`ifdef MEMORY_BOUNDS_CHECK_EN
      check("oob_read", data_out, 32'h0);
`else
      check("wrap_read", data_out, 32'hDEADBEEF);
      req(32'h8011FFFC, 1'b1, 2'b00, 32'h0);
      step();
      check("wrap_alias", data_out, 32'hDEADBEEF);
`endif
      req(c_base, 1'b1, 2'b00, 32'h0);
      step();
      enable = 1'b0;
      check("oob_base_intact", data_out, 32'h1000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
